// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// MemArbiter (module mem_arbiter)
//
// Purpose:
//    Shares one memory port between an instruction-fetch requester (IF) and a
//    data-access requester (D). Only one transaction is in flight at a time.
//    When both requesters ask in the same IDLE cycle, the port goes to the one
//    that was not granted last. A transaction that waits too long for m_ack
//    is aborted with an error pulse and zero read data.
//
// Parameters:
//    TIMEOUT   maximum number of BUSY cycles spent waiting for m_ack (1..255)
//
// Ports:
//    clk       single clock, all state changes on its rising edge
//    rst       synchronous active-low reset
//    if_req    fetch request, held until if_ready
//    if_addr   fetch address
//    if_rdata  fetched word, valid while if_ready is high, held otherwise
//    if_ready  one-cycle fetch completion pulse
//    d_req     data request, held until d_ready
//    d_we      1 = store, 0 = load
//    d_addr    data address
//    d_wdata   store data
//    d_rdata   load data (also captured for stores), held otherwise
//    d_ready   one-cycle data completion pulse
//    m_req     request to the shared memory port
//    m_we      memory write enable
//    m_addr    memory address
//    m_wdata   memory write data
//    m_rdata   memory read data, valid with m_ack
//    m_ack     one-cycle memory completion
//    err       one-cycle pulse when a transaction times out
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      BUSY_IF = 3'd1,
      BUSY_D  = 3'd2,
      DONE_IF = 3'd3,
      DONE_D  = 3'd4
   } state_t;

   typedef enum logic {
      GRANT_IF = 1'b0,
      GRANT_D  = 1'b1
   } grant_t;

   // Counter value on the last BUSY cycle allowed before the abort fires.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q,     state_d;
   grant_t      lastGrant_q, lastGrant_d;
   logic [7:0]  waitCnt_q,   waitCnt_d;
   logic        mReq_q,      mReq_d;
   logic        mWe_q,       mWe_d;
   logic [31:0] mAddr_q,     mAddr_d;
   logic [31:0] mWdata_q,    mWdata_d;
   logic [31:0] ifRdata_q,   ifRdata_d;
   logic [31:0] dRdata_q,    dRdata_d;
   logic        ifReady_q,   ifReady_d;
   logic        dReady_q,    dReady_d;
   logic        err_q,       err_d;

   logic        pickD;
   logic        waitExpired;

   // Data wins in IDLE when it asks alone, or when both ask and the
   // previous grant went to fetch. Reset leaves lastGrant at IF, so the
   // very first tie goes to data.
   assign pickD = d_req && (!if_req || (lastGrant_q == GRANT_IF));

   // True on the final BUSY cycle the wait budget allows.
   assign waitExpired = (waitCnt_q == WAIT_LAST);

   // State register and all registered outputs. Reset is synchronous and
   // active-low, so an in-flight transaction is dropped without any ready
   // pulse and everything returns to zero on that edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         lastGrant_q <= GRANT_IF;
         waitCnt_q   <= 8'd0;
         mReq_q      <= 1'b0;
         mWe_q       <= 1'b0;
         mAddr_q     <= 32'h0;
         mWdata_q    <= 32'h0;
         ifRdata_q   <= 32'h0;
         dRdata_q    <= 32'h0;
         ifReady_q   <= 1'b0;
         dReady_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         waitCnt_q   <= waitCnt_d;
         mReq_q      <= mReq_d;
         mWe_q       <= mWe_d;
         mAddr_q     <= mAddr_d;
         mWdata_q    <= mWdata_d;
         ifRdata_q   <= ifRdata_d;
         dRdata_q    <= dRdata_d;
         ifReady_q   <= ifReady_d;
         dReady_q    <= dReady_d;
         err_q       <= err_d;
      end
   end

   // Next-state and next-output logic. Everything defaults to holding its
   // value, except the three completion pulses which default low so they
   // last exactly the one DONE cycle. Requests and m_ack are only looked at
   // in the states where they matter, which is what makes them ignored
   // everywhere else.
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      waitCnt_d   = waitCnt_q;
      mReq_d      = mReq_q;
      mWe_d       = mWe_q;
      mAddr_d     = mAddr_q;
      mWdata_d    = mWdata_q;
      ifRdata_d   = ifRdata_q;
      dRdata_d    = dRdata_q;
      ifReady_d   = 1'b0;
      dReady_d    = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pickD) begin
               state_d     = BUSY_D;
               lastGrant_d = GRANT_D;
               waitCnt_d   = 8'd0;
               mReq_d      = 1'b1;
               mWe_d       = d_we;
               mAddr_d     = d_addr;
               mWdata_d    = d_wdata;
            end else if (if_req) begin
               state_d     = BUSY_IF;
               lastGrant_d = GRANT_IF;
               waitCnt_d   = 8'd0;
               mReq_d      = 1'b1;
               mWe_d       = 1'b0;
               mAddr_d     = if_addr;
            end else begin
               mReq_d      = 1'b0;
               mWe_d       = 1'b0;
            end
         end

         // An ack on the last allowed cycle still counts as success, so
         // m_ack is tested before the timeout.
         BUSY_IF: begin
            if (m_ack) begin
               state_d   = DONE_IF;
               ifRdata_d = m_rdata;
               ifReady_d = 1'b1;
               mReq_d    = 1'b0;
               mWe_d     = 1'b0;
            end else if (waitExpired) begin
               state_d   = DONE_IF;
               ifRdata_d = 32'h0;
               ifReady_d = 1'b1;
               err_d     = 1'b1;
               mReq_d    = 1'b0;
               mWe_d     = 1'b0;
            end else begin
               waitCnt_d = waitCnt_q + 8'd1;
            end
         end

         // Read data is captured for stores as well as loads; the
         // requester simply ignores it on a store.
         BUSY_D: begin
            if (m_ack) begin
               state_d  = DONE_D;
               dRdata_d = m_rdata;
               dReady_d = 1'b1;
               mReq_d   = 1'b0;
               mWe_d    = 1'b0;
            end else if (waitExpired) begin
               state_d  = DONE_D;
               dRdata_d = 32'h0;
               dReady_d = 1'b1;
               err_d    = 1'b1;
               mReq_d   = 1'b0;
               mWe_d    = 1'b0;
            end else begin
               waitCnt_d = waitCnt_q + 8'd1;
            end
         end

         // One cycle for the requester to see its pulse; the following
         // IDLE cycle is what keeps back-to-back grants apart.
         DONE_IF: state_d = IDLE;
         DONE_D:  state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   assign m_req    = mReq_q;
   assign m_we     = mWe_q;
   assign m_addr   = mAddr_q;
   assign m_wdata  = mWdata_q;
   assign if_rdata = ifRdata_q;
   assign d_rdata  = dRdata_q;
   assign if_ready = ifReady_q;
   assign d_ready  = dReady_q;
   assign err      = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning max cycles BUSY waits for m_ack before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; state clears on a rising clk edge with rst=0.
REQ-004 if_req  input  1  instruction-fetch request, held high until if_ready seen.
REQ-005 if_addr  input  32  fetch address, stable while if_req high.
REQ-006 if_rdata  output  32  fetched word, valid only while if_ready=1.
REQ-007 if_ready  output  1  one-cycle completion pulse for fetch.
REQ-008 d_req  input  1  data-access request, held high until d_ready seen.
REQ-009 d_we  input  1  1=store, 0=load; stable while d_req high.
REQ-010 d_addr  input  32  data address, stable while d_req high.
REQ-011 d_wdata  input  32  store data, stable while d_req high.
REQ-012 d_rdata  output  32  load data, valid only while d_ready=1.
REQ-013 d_ready  output  1  one-cycle completion pulse for data access.
REQ-014 m_req  output  1  request to the single shared memory port.
REQ-015 m_we  output  1  memory write enable.
REQ-016 m_addr  output  32  memory address.
REQ-017 m_wdata  output  32  memory write data.
REQ-018 m_rdata  input  32  memory read data, valid with m_ack.
REQ-019 m_ack  input  1  memory completion, one cycle.
REQ-020 err  output  1  one-cycle pulse when a transaction times out.

Function
REQ-021 FSM states SHALL be IDLE, BUSY_IF, BUSY_D, DONE_IF, DONE_D; all outputs registered.
REQ-022 IDLE, only if_req: next state BUSY_IF; m_req=1, m_we=0, m_addr=if_addr latched.
REQ-023 IDLE, only d_req: next state BUSY_D; m_req=1, m_we=d_we, m_addr=d_addr, m_wdata=d_wdata latched.
REQ-024 IDLE, both requests: grant the port not granted last (round-robin via last_grant register); last_grant updates at every grant.
REQ-025 IDLE, no request: stay IDLE, m_req=0, m_we=0.
REQ-026 BUSY_x: hold m_req, m_we, m_addr, m_wdata constant; new/changed requests ignored.
REQ-027 BUSY_x with m_ack=1: next state DONE_x; latch m_rdata into x_rdata (d_rdata latched for loads and stores), x_ready=1, m_req=0, m_we=0.
REQ-028 BUSY_x timeout: 8-bit wait counter cleared on grant, incremented each BUSY cycle without m_ack; when counter=TIMEOUT-1 and m_ack=0, next state DONE_x with x_ready=1, x_rdata=32'h0, err=1, m_req=0.
REQ-029 m_ack and timeout in same cycle: m_ack wins, err=0.
REQ-030 DONE_x: exactly one cycle; x_ready/err drop at its end; next state IDLE; requests ignored during DONE.
REQ-031 m_ack outside BUSY SHALL be ignored (no state change, no ready pulse).
REQ-032 Minimum transaction: grant edge, ack edge, ready cycle, one IDLE cycle; back-to-back transactions start no sooner than IDLE cycle after DONE.
REQ-033 if_ready and d_ready SHALL never be high in the same cycle; m_we SHALL never be 1 in BUSY_IF.
REQ-034 x_rdata holds last latched value outside ready cycles.

Reset
REQ-035 rst=0 at a clk edge: state=IDLE, last_grant=IF (first tie goes to data), counter=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, if_rdata=0, d_rdata=0, if_ready=0, d_ready=0, err=0.
REQ-036 Reset mid-transaction SHALL abort immediately with no ready pulse; a late m_ack after reset is ignored per REQ-031.

Verification
REQ-037 Single fetch: if_req, if_addr=32'h100, m_ack 2 cycles after m_req with m_rdata=32'h00500093 -> m_addr=32'h100, m_we=0, if_ready one cycle with if_rdata=32'h00500093.
REQ-038 Store: d_req, d_we=1, d_addr=32'h20, d_wdata=32'hCAFEF00D -> m_we=1, m_addr=32'h20, m_wdata=32'hCAFEF00D until m_ack, then d_ready pulse, err=0.
REQ-039 Contention: if_req and d_req both held from reset -> grants D, IF, D, IF alternating; no overlapping ready pulses.
REQ-040 Timeout: TIMEOUT=4, d_req load, m_ack never -> m_req high 4 cycles, then d_ready=1, d_rdata=0, err=1 one cycle; m_ack arriving next cycle ignored.
REQ-041 Ack/timeout tie: TIMEOUT=4, m_ack on 4th BUSY cycle with m_rdata=32'h1234 -> d_rdata=32'h1234, err=0.
REQ-042 Reset mid-BUSY_IF: rst=0 for one edge -> all outputs zero next cycle, no if_ready; subsequent m_ack ignored.
